// File: rtl/fsk_tx_scheduler.sv
// Round-robin scheduler that feeds one of two codeword sources
// to the serializer and FSK encoder, enforcing an inter-frame gap.
module fsk_tx_scheduler #(
  parameter int unsigned CODE_W   = 11,
  parameter int unsigned GAP_CYC  = 64,
  parameter int unsigned START_TO = 32,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              quickclk,
  input  logic              reset,
  input  logic              req0,
  input  logic [CODE_W-1:0] code0,
  output logic              ack0,
  input  logic              req1,
  input  logic [CODE_W-1:0] code1,
  output logic              ack1,
  output logic [CODE_W-1:0] ser_code,
  output logic              ser_send,
  input  logic              ser_sending,
  output logic              fsk_en,
  output logic              busy,
  output logic              grant_id,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err
);

  localparam int unsigned MAXC =
    (GAP_CYC > START_TO) ? GAP_CYC : START_TO;
  localparam int unsigned TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(START_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              send_q, send_d;
  logic              fsk_q, fsk_d;
  logic              gid_q, gid_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              win;

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge quickclk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      send_q  <= 1'b0;
      fsk_q   <= 1'b0;
      gid_q   <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      send_q  <= send_d;
      fsk_q   <= fsk_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state: grant, start timeout, completion and gap counting.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    send_d  = 1'b0;
    fsk_d   = fsk_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    win     = (req0 && req1) ? ptr_q : req1;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_LOAD;
          code_d  = win ? code1 : code0;
          ack0_d  = ~win;
          ack1_d  = win;
          send_d  = 1'b1;
          fsk_d   = 1'b1;
          gid_d   = win;
          ptr_d   = ~win;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT_START;
        tcnt_d  = '0;
      end
      S_WAIT_START: begin
        if (ser_sending) begin
          state_d = S_WAIT_DONE;
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          fsk_d   = 1'b0;
          state_d = S_GAP;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!ser_sending) begin
          cnt_d   = cnt_q + 1'b1;
          fsk_d   = 1'b0;
          state_d = S_GAP;
          tcnt_d  = '0;
        end
      end
      S_GAP: begin
        if (tcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign ser_code  = code_q;
  assign ser_send  = send_q;
  assign fsk_en    = fsk_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = gid_q;
  assign frame_cnt = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// Directed bench for fsk_tx_scheduler: grants, round robin,
// timeout, counter wrap, async reset and gap behaviour.
module tb_fsk_tx_scheduler;

  localparam int GAP = 8;
  localparam int STO = 6;

  logic        quickclk;
  logic        reset;
  logic        req0, req1;
  logic [10:0] code0, code1;
  logic        ack0, ack1;
  logic [10:0] ser_code;
  logic        ser_send;
  logic        ser_sending;
  logic        fsk_en;
  logic        busy;
  logic        grant_id;
  logic [7:0]  frame_cnt;
  logic        err;

  int          total;
  int          bad;
  int          cyc;
  int          send_at;
  int          prev_at;
  logic [7:0]  exp_cnt;
  logic        exp_err;

  fsk_tx_scheduler #(
    .CODE_W(11),
    .GAP_CYC(GAP),
    .START_TO(STO),
    .CNT_W(8)
  ) dut (
    .quickclk(quickclk),
    .reset(reset),
    .req0(req0),
    .code0(code0),
    .ack0(ack0),
    .req1(req1),
    .code1(code1),
    .ack1(ack1),
    .ser_code(ser_code),
    .ser_send(ser_send),
    .ser_sending(ser_sending),
    .fsk_en(fsk_en),
    .busy(busy),
    .grant_id(grant_id),
    .frame_cnt(frame_cnt),
    .err(err)
  );

  initial begin
    quickclk = 1'b0;
    forever #5 quickclk = ~quickclk;
  end

  always @(posedge quickclk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_code"}, 32'(ser_code), 0);
    chk({tag, "_outs"},
        {26'd0, ser_send, ack0, ack1, fsk_en, busy, grant_id}, 0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // Wait for a grant, then act as a serializer that is busy for
  // three cycles. Ends on the first GAP cycle (negedge).
  task automatic frame(input logic id,
                       input logic [10:0] code,
                       input logic hold);
    int n;
    n = 0;
    do begin
      @(negedge quickclk);
      n++;
    end while (!(ack0 || ack1) && n < 200);
    chk("grant_seen", 32'(n < 200), 1);
    chk("ack0", 32'(ack0), 32'(!id));
    chk("ack1", 32'(ack1), 32'(id));
    chk("send_hi", 32'(ser_send), 1);
    chk("code", 32'(ser_code), 32'(code));
    chk("gid", 32'(grant_id), 32'(id));
    chk("fsk_load", 32'(fsk_en), 1);
    prev_at = send_at;
    send_at = cyc;
    if (!hold) begin
      if (id) req1 = 1'b0;
      else    req0 = 1'b0;
    end
    @(negedge quickclk);
    chk("send_lo", 32'(ser_send), 0);
    chk("ack_lo", 32'(ack0 | ack1), 0);
    chk("fsk_ws", 32'(fsk_en), 1);
    ser_sending = 1'b1;
    repeat (3) @(negedge quickclk);
    chk("fsk_wd", 32'(fsk_en), 1);
    ser_sending = 1'b0;
    @(negedge quickclk);
    exp_cnt = exp_cnt + 8'd1;
    chk("cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("fsk_gap", 32'(fsk_en), 0);
    chk("busy_gap", 32'(busy), 1);
    chk("err", 32'(err), 32'(exp_err));
    chk("code_hold", 32'(ser_code), 32'(code));
  endtask

  initial begin
    int acks;
    total = 0;
    bad = 0;
    cyc = 0;
    send_at = 0;
    prev_at = 0;
    exp_cnt = 8'd0;
    exp_err = 1'b0;
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    code0 = 11'h0;
    code1 = 11'h0;
    ser_sending = 1'b0;
    #2;
    chk_reset_vals("rst");
    repeat (2) @(negedge quickclk);
    reset = 1'b1;

    // Single request right after reset: grant on the next edge.
    req0 = 1'b1;
    code0 = 11'h5A3;
    @(negedge quickclk);
    chk("lat1_ack0", 32'(ack0), 1);
    chk("lat1_send", 32'(ser_send), 1);
    req0 = 1'b0;
    @(negedge quickclk);
    chk("lat1_send_lo", 32'(ser_send), 0);
    ser_sending = 1'b1;
    repeat (3) @(negedge quickclk);
    chk("lat1_fsk", 32'(fsk_en), 1);
    ser_sending = 1'b0;
    @(negedge quickclk);
    chk("lat1_cnt", 32'(frame_cnt), 1);
    chk("lat1_fsk_off", 32'(fsk_en), 0);
    chk("lat1_code", 32'(ser_code), 32'h5A3);
    exp_cnt = 8'd1;

    // Abort a req0 frame by reset in WAIT_DONE (pointer now at 1).
    req0 = 1'b1;
    code0 = 11'h2AA;
    frame_wait_start();
    req0 = 1'b0;
    @(negedge quickclk);
    ser_sending = 1'b1;
    @(negedge quickclk);
    chk("wd_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("arst");
    ser_sending = 1'b0;
    repeat (2) @(negedge quickclk);
    reset = 1'b1;
    exp_cnt = 8'd0;

    // Both held: pointer back at 0, grants alternate 0,1,0,1.
    // Grant-to-grant: LOAD+WAIT_START+3 WAIT_DONE+GAP+1 IDLE.
    req0 = 1'b1;
    code0 = 11'h001;
    req1 = 1'b1;
    code1 = 11'h7FF;
    for (int i = 0; i < 4; i++) begin
      frame(logic'(i[0]), i[0] ? 11'h7FF : 11'h001, 1'b1);
      if (i > 0) chk("spacing", 32'(send_at - prev_at), 32'(GAP + 6));
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Requester 0 alone, held: back-to-back frames until wrap.
    req0 = 1'b1;
    code0 = 11'h155;
    for (int i = 0; i < 252; i++) begin
      frame(1'b0, 11'h155, 1'b1);
      if (i > 0) chk("b2b", 32'(send_at - prev_at), 32'(GAP + 6));
    end
    req0 = 1'b0;
    chk("wrap", 32'(frame_cnt), 0);
    chk("wrap_err", 32'(err), 0);

    // Start timeout: the serializer never answers.
    req1 = 1'b1;
    code1 = 11'h3C3;
    frame_wait_start();
    chk("to_ack1", 32'(ack1), 1);
    req1 = 1'b0;
    repeat (STO) @(negedge quickclk);
    chk("to_err_early", 32'(err), 0);
    chk("to_fsk_early", 32'(fsk_en), 1);
    @(negedge quickclk);
    chk("to_err", 32'(err), 1);
    chk("to_fsk", 32'(fsk_en), 0);
    chk("to_cnt", 32'(frame_cnt), 0);
    chk("to_busy", 32'(busy), 1);
    exp_err = 1'b1;
    req1 = 1'b1;
    code1 = 11'h0F0;
    frame(1'b1, 11'h0F0, 1'b0);

    // Short req1 pulse inside GAP is never sampled.
    @(negedge quickclk);
    req1 = 1'b1;
    @(negedge quickclk);
    req1 = 1'b0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge quickclk);
      if (ack0 || ack1 || ser_send) acks++;
    end
    chk("gap_pulse_ack", 32'(acks), 0);
    chk("gap_pulse_idle", 32'(busy), 0);
    chk("gap_pulse_cnt", 32'(frame_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bounded wait for the grant cycle with the request already set.
  task automatic frame_wait_start();
    int n;
    n = 0;
    do begin
      @(negedge quickclk);
      n++;
    end while (!(ack0 || ack1) && n < 200);
    chk("grant_wait", 32'(n < 200), 1);
  endtask

endmodule
